// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator control path: operand and result
// widths, the ALU mode encoding, the sequencer state type and the helper
// that turns a mode into the thermometer pattern shown on the mode LEDs.
// ---------------------------------------------------------------------------
package calc_pkg;

    localparam int OPERAND_W = 4;
    localparam int RESULT_W  = 14;

    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_SUB = 2'd1;
    localparam logic [1:0] MODE_MUL = 2'd2;
    localparam logic [1:0] MODE_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_SHOW
    } state_t;

    // Bit 0 is always lit; bit k lights once the mode has reached k.
    function automatic logic [3:0] mode_leds(input logic [1:0] mode);
        mode_leds = {mode == MODE_DIV, mode >= MODE_MUL, mode >= MODE_SUB, 1'b1};
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Front end for one active-low push button: two-flop synchronizer, a
// debounce counter that only accepts a new level after DEBOUNCE_CYCLES
// identical synchronized samples, and a one-cycle pulse on each accepted
// released->pressed transition.
//
// Ports:
//   clock  in  system clock
//   rst_n  in  asynchronous active-low reset (debounced level -> released)
//   btn    in  raw button, active-low, asynchronous to clock
//   press  out one-cycle press event
// ---------------------------------------------------------------------------
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // The counter tracks how long the synchronized input has disagreed with
    // the accepted level; any agreeing sample restarts the run. Only a
    // change towards pressed (low) produces an event, so a held button or a
    // release never fires.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            press   <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_q2;
                cnt   <= '0;
                press <= ~sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Control sequencer between the board pins and the calculator ALU. Keeps the
// operation mode, latches operands on a result request, runs a start/done
// handshake (with timeout) to the ALU and registers the result and alert
// for the display path.
//
// Ports:
//   clock        in   system clock
//   btn_reset    in   asynchronous active-low reset
//   btn_modo     in   raw mode button (active-low)
//   btn_res      in   raw result button (active-low)
//   sw_a, sw_b   in   operand switches
//   alu_a/alu_b  out  latched operands
//   alu_mode     out  latched mode (add, sub, mul, div)
//   alu_start    out  one-cycle start pulse
//   alu_done     in   ALU result valid
//   alu_result   in   ALU result
//   alu_alert    in   ALU alert flag
//   result       out  registered result for display
//   result_valid out  result digits shown
//   led_alerta   out  registered alert
//   led_modo     out  thermometer mode LEDs
//   busy         out  operation in flight
// ---------------------------------------------------------------------------
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALU_TIMEOUT     = 32
) (
    input  logic                 clock,
    input  logic                 btn_reset,
    input  logic                 btn_modo,
    input  logic                 btn_res,
    input  logic [OPERAND_W-1:0] sw_a,
    input  logic [OPERAND_W-1:0] sw_b,
    output logic [OPERAND_W-1:0] alu_a,
    output logic [OPERAND_W-1:0] alu_b,
    output logic [1:0]           alu_mode,
    output logic                 alu_start,
    input  logic                 alu_done,
    input  logic [RESULT_W-1:0]  alu_result,
    input  logic                 alu_alert,
    output logic [RESULT_W-1:0]  result,
    output logic                 result_valid,
    output logic                 led_alerta,
    output logic [3:0]           led_modo,
    output logic                 busy
);

    localparam int TCNT_W = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(ALU_TIMEOUT);

    logic              modo_ev;
    logic              res_ev;
    state_t            state;
    logic [1:0]        mode;
    logic [1:0]        mode_next;
    logic [TCNT_W-1:0] tcnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_modo (
        .clock (clock),
        .rst_n (btn_reset),
        .btn   (btn_modo),
        .press (modo_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_res (
        .clock (clock),
        .rst_n (btn_reset),
        .btn   (btn_res),
        .press (res_ev)
    );

    // Two-bit mode wraps from divide back to add on its own.
    assign mode_next = mode + 2'd1;

    // Sequencer. Button events are only looked at in IDLE/SHOW, so anything
    // pressed while an operation is in flight is simply lost. The timeout
    // counter reads 1 during EXEC; done is honoured even in the last
    // allowed cycle, ahead of the timeout.
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            state        <= ST_IDLE;
            mode         <= MODE_ADD;
            led_modo     <= 4'b0001;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_mode     <= MODE_ADD;
            alu_start    <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            led_alerta   <= 1'b0;
            busy         <= 1'b0;
            tcnt         <= '0;
        end else begin
            alu_start <= 1'b0;
            case (state)
                ST_IDLE, ST_SHOW: begin
                    if (res_ev) begin
                        alu_a     <= sw_a;
                        alu_b     <= sw_b;
                        alu_mode  <= mode;
                        alu_start <= 1'b1;
                        busy      <= 1'b1;
                        tcnt      <= TCNT_W'(1);
                        state     <= ST_EXEC;
                    end else if (modo_ev) begin
                        mode         <= mode_next;
                        led_modo     <= mode_leds(mode_next);
                        result       <= '0;
                        result_valid <= 1'b0;
                        led_alerta   <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_EXEC, ST_WAIT: begin
                    if (alu_done) begin
                        result       <= alu_result;
                        led_alerta   <= alu_alert;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_SHOW;
                    end else if (tcnt == TCNT_LAST) begin
                        result       <= '0;
                        led_alerta   <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= ST_SHOW;
                    end else begin
                        tcnt  <= tcnt + 1'b1;
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Directed plus randomized bench for calc_sequencer. A simple ALU stand-in
// answers after a programmable number of busy cycles (or never), and the
// expected mode, result and alert are worked out from the arithmetic rules
// of the calculator.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;

    localparam int DEB    = 16;
    localparam int TMO    = 32;
    localparam int SETTLE = DEB + 8;

    logic        clock = 1'b0;
    logic        btn_reset = 1'b0;
    logic        btn_modo = 1'b1;
    logic        btn_res = 1'b1;
    logic [3:0]  sw_a = 4'd0;
    logic [3:0]  sw_b = 4'd0;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [1:0]  alu_mode;
    logic        alu_start;
    logic        alu_done;
    logic [13:0] alu_result;
    logic        alu_alert;
    logic [13:0] result;
    logic        result_valid;
    logic        led_alerta;
    logic [3:0]  led_modo;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int start_count = 0;
    int done_cycle = 0;
    int cyc = 0;
    int exp_mode = 0;
    bit exp_show = 1'b0;
    bit force_done = 1'b0;

    calc_sequencer #(.DEBOUNCE_CYCLES(DEB), .ALU_TIMEOUT(TMO)) dut (
        .clock        (clock),
        .btn_reset    (btn_reset),
        .btn_modo     (btn_modo),
        .btn_res      (btn_res),
        .sw_a         (sw_a),
        .sw_b         (sw_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_mode     (alu_mode),
        .alu_start    (alu_start),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_alert    (alu_alert),
        .result       (result),
        .result_valid (result_valid),
        .led_alerta   (led_alerta),
        .led_modo     (led_modo),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    // Calculator arithmetic: subtraction shows the magnitude and flags a
    // negative result; division by zero shows 0 with the alert.
    function automatic int alu_res(input int a, input int b, input int m);
        case (m)
            0:       return a + b;
            1:       return (a >= b) ? a - b : b - a;
            2:       return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    function automatic int alu_alt(input int a, input int b, input int m);
        return ((m == 1 && a < b) || (m == 3 && b == 0)) ? 1 : 0;
    endfunction

    function automatic int leds_of(input int m);
        return (1 << (m + 1)) - 1;
    endfunction

    // ALU stand-in: done appears in busy cycle done_cycle (EXEC is cycle 1,
    // so done_cycle=1 behaves like a combinational ALU); 0 means never.
    assign alu_result = 14'(alu_res(int'(alu_a), int'(alu_b), int'(alu_mode)));
    assign alu_alert  = alu_alt(int'(alu_a), int'(alu_b), int'(alu_mode)) != 0;
    assign alu_done   = force_done ||
                        (done_cycle != 0 && (alu_start ? 1 : cyc) == done_cycle);

    always @(posedge clock) begin
        if (alu_start) begin
            cyc         <= 2;
            start_count <= start_count + 1;
        end else if (cyc != 0 && cyc < 1000) begin
            cyc <= cyc + 1;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_modo();
        btn_modo = 1'b0;
        wait_cycles(SETTLE);
        btn_modo = 1'b1;
        wait_cycles(SETTLE);
        exp_mode = (exp_mode + 1) % 4;
        check_output("led_modo", 32'(led_modo), leds_of(exp_mode));
        if (exp_show) begin
            check_output("cleared_valid", 32'(result_valid), 0);
            check_output("cleared_result", 32'(result), 0);
            check_output("cleared_alert", 32'(led_alerta), 0);
            exp_show = 1'b0;
        end
    endtask

    // One result request. modo_off >= 0 also presses the mode button that
    // many cycles after the result button.
    task automatic apply_stimulus(input int a, input int b, input int dc, input int modo_off);
        int s0;
        int n;
        int er;
        int ea;
        sw_a       = 4'(a);
        sw_b       = 4'(b);
        done_cycle = dc;
        s0         = start_count;
        btn_res    = 1'b0;
        n = 0;
        while (alu_start !== 1'b1 && n < 60) begin
            if (n == modo_off) btn_modo = 1'b0;
            @(negedge clock);
            n++;
        end
        check_output("start_seen", 32'(alu_start), 1);
        check_output("alu_a", 32'(alu_a), a);
        check_output("alu_b", 32'(alu_b), b);
        check_output("alu_mode", 32'(alu_mode), exp_mode);
        sw_a = 4'($urandom_range(0, 15));
        sw_b = 4'($urandom_range(0, 15));
        n = 0;
        while (busy === 1'b1 && n < 80) begin
            n++;
            @(negedge clock);
        end
        check_output("busy_cycles", n, (dc == 0) ? TMO : dc);
        if (dc == 0) begin
            er = 0;
            ea = 1;
        end else begin
            er = alu_res(a, b, exp_mode);
            ea = alu_alt(a, b, exp_mode);
        end
        check_output("result", 32'(result), er);
        check_output("led_alerta", 32'(led_alerta), ea);
        check_output("result_valid", 32'(result_valid), 1);
        check_output("alu_a_hold", 32'(alu_a), a);
        btn_res  = 1'b1;
        btn_modo = 1'b1;
        wait_cycles(SETTLE);
        check_output("start_pulses", start_count - s0, 1);
        check_output("mode_kept", 32'(led_modo), leds_of(exp_mode));
        exp_show = 1'b1;
    endtask

    initial begin
        int s0;
        $display("[TB] reset");
        wait_cycles(3);
        btn_reset = 1'b1;
        wait_cycles(2);
        check_output("rst_led_modo", 32'(led_modo), 1);
        check_output("rst_valid", 32'(result_valid), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_result", 32'(result), 0);
        check_output("rst_start", 32'(alu_start), 0);

        $display("[TB] mode cycling");
        repeat (4) press_modo();

        $display("[TB] combinational add");
        apply_stimulus(9, 7, 1, -1);
        repeat (3) press_modo();

        $display("[TB] multi-cycle divide by zero, mode press while busy");
        apply_stimulus(0, 0, 10, 3);

        $display("[TB] timeout");
        apply_stimulus(8, 2, 0, -1);
        force_done = 1'b1;
        wait_cycles(2);
        force_done = 1'b0;
        wait_cycles(2);
        check_output("stray_result", 32'(result), 0);
        check_output("stray_alert", 32'(led_alerta), 1);
        check_output("stray_valid", 32'(result_valid), 1);
        check_output("stray_busy", 32'(busy), 0);

        $display("[TB] bounce");
        sw_a = 4'd4;
        sw_b = 4'd2;
        done_cycle = 1;
        s0 = start_count;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_res = ~btn_res;
            @(negedge clock);
        end
        btn_res = 1'b0;
        wait_cycles(40);
        check_output("bounce_starts", start_count - s0, 1);
        check_output("bounce_result", 32'(result), 2);
        btn_res = 1'b1;
        wait_cycles(SETTLE);
        s0 = start_count;
        btn_res = 1'b0;
        wait_cycles(5);
        btn_res = 1'b1;
        wait_cycles(40);
        check_output("glitch_starts", start_count - s0, 0);

        $display("[TB] simultaneous presses");
        repeat (2) press_modo();
        apply_stimulus(3, 5, 1, 0);

        $display("[TB] reset during WAIT");
        sw_a = 4'd6;
        sw_b = 4'd2;
        done_cycle = 20;
        btn_res = 1'b0;
        for (int i = 0; i < 60 && alu_start !== 1'b1; i++) @(negedge clock);
        wait_cycles(5);
        check_output("pre_reset_busy", 32'(busy), 1);
        btn_res = 1'b1;
        btn_reset = 1'b0;
        #1;
        check_output("arst_busy", 32'(busy), 0);
        check_output("arst_valid", 32'(result_valid), 0);
        check_output("arst_result", 32'(result), 0);
        check_output("arst_alert", 32'(led_alerta), 0);
        check_output("arst_alu_a", 32'(alu_a), 0);
        check_output("arst_alu_mode", 32'(alu_mode), 0);
        check_output("arst_led_modo", 32'(led_modo), 1);
        exp_mode = 0;
        exp_show = 1'b0;
        @(negedge clock);
        btn_reset = 1'b1;
        wait_cycles(30);
        check_output("late_done_valid", 32'(result_valid), 0);
        check_output("late_done_busy", 32'(busy), 0);

        $display("[TB] randomized operations");
        for (int k = 0; k < 8; k++) begin
            int presses;
            int dc;
            presses = $urandom_range(0, 2);
            repeat (presses) press_modo();
            dc = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
            apply_stimulus($urandom_range(0, 15), $urandom_range(0, 15), dc, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
